// File: rtl/cpu_eu_mc.sv
// Execution unit: register file, ALU, sign extender, datapath muxes and a
// sequential shift-add HI/LO multiplier behind a valid/ready issue handshake.
module cpu_eu_mc #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              valid_in,
    output logic              ready_out,
    input  logic              RegDst,
    input  logic              ALUSrc,
    input  logic              RegWrite,
    input  logic              MemtoReg,
    input  logic [1:0]        ALUOp,
    input  logic [25:0]       Instruction,
    input  logic [DATA_W-1:0] Data_from_Ram,
    output logic [DATA_W-1:0] SEImm,
    output logic [DATA_W-1:0] RAM_Address,
    output logic [DATA_W-1:0] Data_to_Ram,
    output logic              Zero,
    output logic              busy
);
    localparam int unsigned NREG  = 1 << REG_AW;
    localparam int unsigned SH_W  = $clog2(DATA_W);
    localparam int unsigned CNT_W = $clog2(DATA_W) + 1;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_FIX} state_e;

    logic [DATA_W-1:0]   regs_q [NREG];
    logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [DATA_W-1:0]   mcand_q, mcand_d;
    logic [2*DATA_W-1:0] acc_q, acc_d, prod;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                neg_q, neg_d;
    state_e              state_q, state_d;

    logic [REG_AW-1:0] rs, rt, rd, wa;
    logic [5:0]        funct;
    logic [SH_W-1:0]   sh;
    logic [DATA_W-1:0] a, b_reg, b, alu_res, wdata, abs_a, abs_b;
    logic [DATA_W:0]   mul_sum;
    logic              wr_ok, mul_start, mul_signed, accept, we;
    logic              unused_instr;

    assign rs    = Instruction[21 +: REG_AW];
    assign rt    = Instruction[16 +: REG_AW];
    assign rd    = Instruction[11 +: REG_AW];
    assign funct = Instruction[5:0];
    assign sh    = SH_W'(32'(Instruction[10:6]) % DATA_W);
    // Upper register-field bits are intentionally ignored for small register files.
    assign unused_instr = ^Instruction;

    assign SEImm       = DATA_W'($signed(Instruction[15:0]));
    assign a           = regs_q[rs];
    assign b_reg       = regs_q[rt];
    assign b           = ALUSrc ? SEImm : b_reg;
    assign Data_to_Ram = b_reg;
    assign RAM_Address = alu_res;
    assign Zero        = (alu_res == '0);
    assign ready_out   = (state_q == S_IDLE);
    assign busy        = !ready_out;

    // ALU and funct decode
    always_comb begin
        alu_res    = '0;
        wr_ok      = 1'b1;
        mul_start  = 1'b0;
        mul_signed = 1'b0;
        case (ALUOp)
            2'b00: alu_res = a + b;
            2'b01: alu_res = a - b;
            2'b11: alu_res = DATA_W'($signed(a) < $signed(b));
            default: begin
                case (funct)
                    6'b100000, 6'b100001: alu_res = a + b;
                    6'b100010, 6'b100011: alu_res = a - b;
                    6'b100100: alu_res = a & b;
                    6'b100101: alu_res = a | b;
                    6'b100110: alu_res = a ^ b;
                    6'b100111: alu_res = ~(a | b);
                    6'b101010: alu_res = DATA_W'($signed(a) < $signed(b));
                    6'b101011: alu_res = DATA_W'(a < b);
                    6'b000000: alu_res = b << sh;
                    6'b000010: alu_res = b >> sh;
                    6'b000011: alu_res = $signed(b) >>> sh;
                    6'b010000: alu_res = hi_q;
                    6'b010010: alu_res = lo_q;
                    6'b011000, 6'b011001: begin
                        wr_ok      = 1'b0;
                        mul_start  = 1'b1;
                        mul_signed = ~funct[0];
                    end
                    default: wr_ok = 1'b0;
                endcase
            end
        endcase
    end

    assign accept = valid_in && ready_out;
    assign wa     = RegDst ? rd : rt;
    assign wdata  = MemtoReg ? Data_from_Ram : alu_res;
    assign we     = accept && RegWrite && wr_ok && (wa != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
        end else if (we) begin
            regs_q[wa] <= wdata;
        end
    end

    // Multiplier operands are magnitudes; the sign is restored in FIX
    assign abs_a   = (mul_signed && a[DATA_W-1]) ? -a : a;
    assign abs_b   = (mul_signed && b[DATA_W-1]) ? -b : b;
    assign mul_sum = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + {1'b0, (acc_q[0] ? mcand_q : '0)};
    assign prod    = neg_q ? -acc_q : acc_q;

    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (accept && mul_start) begin
                    mcand_d = abs_a;
                    acc_d   = {DATA_W'(0), abs_b};
                    cnt_d   = CNT_W'(DATA_W);
                    neg_d   = mul_signed && (a[DATA_W-1] ^ b[DATA_W-1]);
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                acc_d = {mul_sum, acc_q[DATA_W-1:1]};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = S_FIX;
            end
            S_FIX: begin
                hi_d    = prod[2*DATA_W-1:DATA_W];
                lo_d    = prod[DATA_W-1:0];
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            mcand_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end
endmodule

// File: tb/tb_cpu_eu_mc.sv
// Directed bench for cpu_eu_mc: a 32-bit/32-register instance and a
// 16-bit/16-register instance share controls; each has its own valid.
module tb_cpu_eu_mc;
    localparam logic [3:0] C_RALU = 4'b1010;   // {RegDst,ALUSrc,RegWrite,MemtoReg}
    localparam logic [3:0] C_LW   = 4'b0111;
    localparam logic [3:0] C_SW   = 4'b0100;
    localparam logic [3:0] C_BEQ  = 4'b0000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        v32, v16;
    logic        reg_dst, alu_src, reg_write, mem_to_reg;
    logic [1:0]  alu_op;
    logic [25:0] instr;
    logic [31:0] dram;

    logic        rdy32, busy32, z32;
    logic [31:0] se32, ra32, dr32;
    logic        rdy16, busy16, z16;
    logic [15:0] se16, ra16, dr16;

    logic [31:0] o_ra, o_dr, o_se, pv;
    logic        o_z;
    int          vectors = 0;
    int          miscompares = 0;
    int          n;

    always #5 clk = ~clk;

    cpu_eu_mc dut32 (
        .clk(clk), .reset_n(reset_n), .valid_in(v32), .ready_out(rdy32),
        .RegDst(reg_dst), .ALUSrc(alu_src), .RegWrite(reg_write), .MemtoReg(mem_to_reg),
        .ALUOp(alu_op), .Instruction(instr), .Data_from_Ram(dram),
        .SEImm(se32), .RAM_Address(ra32), .Data_to_Ram(dr32), .Zero(z32), .busy(busy32)
    );

    cpu_eu_mc #(.DATA_W(16), .REG_AW(4)) dut16 (
        .clk(clk), .reset_n(reset_n), .valid_in(v16), .ready_out(rdy16),
        .RegDst(reg_dst), .ALUSrc(alu_src), .RegWrite(reg_write), .MemtoReg(mem_to_reg),
        .ALUOp(alu_op), .Instruction(instr), .Data_from_Ram(dram[15:0]),
        .SEImm(se16), .RAM_Address(ra16), .Data_to_Ram(dr16), .Zero(z16), .busy(busy16)
    );

    function automatic logic [25:0] rtype(input logic [4:0] rs, rt, rd, sa, input logic [5:0] fn);
        return {rs, rt, rd, sa, fn};
    endfunction

    function automatic logic [25:0] itype(input logic [4:0] rs, rt, input logic [15:0] imm);
        return {rs, rt, imm};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one instruction, capture combinational outputs, then clock it in
    task automatic issue(input logic s16, input logic [3:0] ctl, input logic [1:0] op,
                         input logic [25:0] ins, input logic [31:0] dm);
        {reg_dst, alu_src, reg_write, mem_to_reg} = ctl;
        alu_op = op;
        instr  = ins;
        dram   = dm;
        v32    = !s16;
        v16    = s16;
        #1;
        o_ra = s16 ? 32'(ra16) : ra32;
        o_dr = s16 ? 32'(dr16) : dr32;
        o_se = s16 ? 32'(se16) : se32;
        o_z  = s16 ? z16 : z32;
        @(posedge clk);
        #1;
        v32 = 1'b0;
        v16 = 1'b0;
    endtask

    // Read a register through addu R0,Rr,R0 without issuing it
    task automatic peek(input logic s16, input logic [4:0] r, output logic [31:0] v);
        {reg_dst, alu_src, reg_write, mem_to_reg} = C_RALU;
        alu_op = 2'b10;
        instr  = rtype(r, 5'd0, 5'd0, 5'd0, 6'b100001);
        v32    = 1'b0;
        v16    = 1'b0;
        #1;
        v = s16 ? 32'(ra16) : ra32;
    endtask

    task automatic load(input logic s16, input logic [4:0] r, input logic [31:0] val);
        issue(s16, C_LW, 2'b00, itype(5'd0, r, 16'd0), val);
    endtask

    task automatic wait_idle(input logic s16, output int cnt);
        cnt = 0;
        while ((s16 ? busy16 : busy32) && cnt < 200) begin
            cnt++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset_n = 1'b0;
        v32 = 1'b0; v16 = 1'b0;
        {reg_dst, alu_src, reg_write, mem_to_reg} = 4'b0000;
        alu_op = 2'b00; instr = '0; dram = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy32", 32'(busy32), 32'd0);
        chk("rst_ready32", 32'(rdy32), 32'd1);
        chk("rst_addr32", ra32, 32'd0);
        chk("rst_dtr32", dr32, 32'd0);
        chk("rst_se32", se32, 32'd0);
        chk("rst_zero32", 32'(z32), 32'd1);
        chk("rst_busy16", 32'(busy16), 32'd0);
        chk("rst_zero16", 32'(z16), 32'd1);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        issue(1'b0, C_RALU, 2'b10, rtype(5'd0, 5'd0, 5'd31, 5'd0, 6'b100111), '0);
        peek(1'b0, 5'd31, pv);  chk("nor_r31", pv, 32'hFFFF_FFFF);
        load(1'b0, 5'd1, 32'd5);
        issue(1'b0, C_RALU, 2'b10, rtype(5'd0, 5'd31, 5'd1, 5'd0, 6'b101010), '0);
        chk("slt_res", o_ra, 32'd0);
        peek(1'b0, 5'd1, pv);   chk("slt_r1", pv, 32'd0);
        issue(1'b0, C_RALU, 2'b10, rtype(5'd0, 5'd31, 5'd1, 5'd0, 6'b101011), '0);
        peek(1'b0, 5'd1, pv);   chk("sltu_r1", pv, 32'd1);

        issue(1'b0, C_LW, 2'b00, itype(5'd0, 5'd5, 16'd4), 32'h1234_1234);
        chk("lw_addr", o_ra, 32'd4);
        peek(1'b0, 5'd5, pv);   chk("lw_r5", pv, 32'h1234_1234);
        load(1'b0, 5'd3, 32'hFFFF_FFFE);
        issue(1'b0, C_SW, 2'b00, itype(5'd5, 5'd3, 16'd12), 32'h0BAD_0BAD);
        chk("sw_addr", o_ra, 32'h1234_1240);
        chk("sw_data", o_dr, 32'hFFFF_FFFE);
        peek(1'b0, 5'd3, pv);   chk("sw_nowrite", pv, 32'hFFFF_FFFE);
        load(1'b0, 5'd2, 32'd1);
        issue(1'b0, C_BEQ, 2'b01, itype(5'd1, 5'd2, 16'hFFF0), '0);
        chk("beq_eq_zero", 32'(o_z), 32'd1);
        chk("seimm_neg", o_se, 32'hFFFF_FFF0);
        issue(1'b0, C_BEQ, 2'b01, itype(5'd1, 5'd3, 16'h0010), '0);
        chk("beq_ne_zero", 32'(o_z), 32'd0);

        load(1'b0, 5'd6, 32'h8000_0001);
        issue(1'b0, C_RALU, 2'b10, rtype(5'd0, 5'd6, 5'd9, 5'd4, 6'b000000), '0);
        chk("sll4", o_ra, 32'h0000_0010);
        issue(1'b0, C_RALU, 2'b10, rtype(5'd0, 5'd6, 5'd9, 5'd4, 6'b000010), '0);
        chk("srl4", o_ra, 32'h0800_0000);
        issue(1'b0, C_RALU, 2'b10, rtype(5'd0, 5'd6, 5'd9, 5'd4, 6'b000011), '0);
        peek(1'b0, 5'd9, pv);   chk("sra4_r9", pv, 32'hF800_0000);

        load(1'b0, 5'd0, 32'hDEAD_BEEF);
        peek(1'b0, 5'd0, pv);   chk("r0_hold", pv, 32'd0);
        load(1'b0, 5'd12, 32'd7);
        issue(1'b0, C_RALU, 2'b10, rtype(5'd0, 5'd0, 5'd12, 5'd0, 6'b111111), '0);
        chk("badfn_res", o_ra, 32'd0);
        peek(1'b0, 5'd12, pv);  chk("badfn_nowr", pv, 32'd7);

        load(1'b0, 5'd7, 32'hFFFF_FFFD);
        load(1'b0, 5'd8, 32'd7);
        issue(1'b0, C_RALU, 2'b10, rtype(5'd7, 5'd8, 5'd0, 5'd0, 6'b011000), '0);
        chk("mul_busy", 32'(busy32), 32'd1);
        chk("mul_notready", 32'(rdy32), 32'd0);
        load(1'b0, 5'd13, 32'h0000_0055);
        issue(1'b0, C_RALU, 2'b10, rtype(5'd0, 5'd0, 5'd14, 5'd0, 6'b010010), '0);
        chk("lo_old_busy", o_ra, 32'd0);
        wait_idle(1'b0, n);
        chk("mult_latency", 32'(n + 2), 32'd33);
        peek(1'b0, 5'd13, pv);  chk("busy_ignored", pv, 32'd0);
        issue(1'b0, C_RALU, 2'b10, rtype(5'd0, 5'd0, 5'd14, 5'd0, 6'b010010), '0);
        chk("mflo", o_ra, 32'hFFFF_FFEB);
        issue(1'b0, C_RALU, 2'b10, rtype(5'd0, 5'd0, 5'd14, 5'd0, 6'b010000), '0);
        chk("mfhi", o_ra, 32'hFFFF_FFFF);

        load(1'b0, 5'd15, 32'hFFFF_FFFF);
        load(1'b0, 5'd16, 32'd2);
        issue(1'b0, C_RALU, 2'b10, rtype(5'd15, 5'd16, 5'd0, 5'd0, 6'b011001), '0);
        wait_idle(1'b0, n);
        issue(1'b0, C_RALU, 2'b10, rtype(5'd0, 5'd0, 5'd14, 5'd0, 6'b010000), '0);
        chk("multu_hi", o_ra, 32'd1);
        issue(1'b0, C_RALU, 2'b10, rtype(5'd0, 5'd0, 5'd14, 5'd0, 6'b010010), '0);
        chk("multu_lo", o_ra, 32'hFFFF_FFFE);

        issue(1'b0, C_RALU, 2'b10, rtype(5'd7, 5'd8, 5'd0, 5'd0, 6'b011000), '0);
        repeat (9) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy32), 32'd0);
        chk("abort_ready", 32'(rdy32), 32'd1);
        alu_op = 2'b10;
        instr  = rtype(5'd0, 5'd0, 5'd0, 5'd0, 6'b010010);
        #1;
        chk("abort_lo", ra32, 32'd0);
        instr  = rtype(5'd0, 5'd0, 5'd0, 5'd0, 6'b010000);
        #1;
        chk("abort_hi", ra32, 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        load(1'b0, 5'd1, 32'd3);
        load(1'b0, 5'd2, 32'd4);
        issue(1'b0, C_RALU, 2'b10, rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'b100000), '0);
        chk("post_abort_add", o_ra, 32'd7);
        peek(1'b0, 5'd3, pv);   chk("post_abort_r3", pv, 32'd7);

        issue(1'b1, C_RALU, 2'b10, rtype(5'd0, 5'd0, 5'd15, 5'd0, 6'b100111), '0);
        peek(1'b1, 5'd15, pv);  chk("w16_nor_r15", pv, 32'h0000_FFFF);
        issue(1'b1, C_RALU, 2'b10, rtype(5'd0, 5'd15, 5'd1, 5'd0, 6'b101011), '0);
        peek(1'b1, 5'd1, pv);   chk("w16_sltu", pv, 32'd1);
        load(1'b1, 5'd4, 32'h0000_8001);
        issue(1'b1, C_RALU, 2'b10, rtype(5'd0, 5'd4, 5'd7, 5'd20, 6'b000000), '0);
        chk("w16_sll20", o_ra, 32'h0000_0010);
        issue(1'b1, C_RALU, 2'b10, rtype(5'd0, 5'd4, 5'd7, 5'd20, 6'b000011), '0);
        chk("w16_sra20", o_ra, 32'h0000_F800);

        load(1'b1, 5'd5, 32'h0000_FFFD);
        load(1'b1, 5'd6, 32'd7);
        issue(1'b1, C_RALU, 2'b10, rtype(5'd5, 5'd6, 5'd0, 5'd0, 6'b011000), '0);
        wait_idle(1'b1, n);
        chk("w16_latency", 32'(n), 32'd17);
        issue(1'b1, C_RALU, 2'b10, rtype(5'd0, 5'd0, 5'd8, 5'd0, 6'b010010), '0);
        chk("w16_mflo", o_ra, 32'h0000_FFEB);
        issue(1'b1, C_RALU, 2'b10, rtype(5'd0, 5'd0, 5'd8, 5'd0, 6'b010000), '0);
        chk("w16_mfhi", o_ra, 32'h0000_FFFF);
        load(1'b1, 5'd2, 32'h0000_8000);
        load(1'b1, 5'd3, 32'h0000_8000);
        issue(1'b1, C_RALU, 2'b10, rtype(5'd2, 5'd3, 5'd0, 5'd0, 6'b011000), '0);
        wait_idle(1'b1, n);
        issue(1'b1, C_RALU, 2'b10, rtype(5'd0, 5'd0, 5'd8, 5'd0, 6'b010000), '0);
        chk("w16_min_hi", o_ra, 32'h0000_4000);
        issue(1'b1, C_RALU, 2'b10, rtype(5'd0, 5'd0, 5'd8, 5'd0, 6'b010010), '0);
        chk("w16_min_lo", o_ra, 32'h0000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
